alu_control_mdu: RTL



---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_control_mdu_if.sv | 20 ++
 rtl/mdu_core.sv | 121 ++++++++++++
 rtl/alu_control_mdu.sv | 88 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct/Other opcode constants and MDU state type
// for the EX-stage decoder and multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SLL     = 4'd3;
  localparam logic [3:0] ALU_SRL     = 4'd4;
  localparam logic [3:0] ALU_SRA     = 4'd5;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_SLTU    = 4'd8;
  localparam logic [3:0] ALU_MFHI    = 4'd9;
  localparam logic [3:0] ALU_MFLO    = 4'd10;
  localparam logic [3:0] ALU_MDU     = 4'd11;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_XOR     = 4'd13;
  localparam logic [3:0] ALU_INVALID = 4'd15;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  localparam logic [3:0] O_ADDI  = 4'd0;
  localparam logic [3:0] O_ANDI  = 4'd1;
  localparam logic [3:0] O_ORI   = 4'd2;
  localparam logic [3:0] O_XORI  = 4'd3;
  localparam logic [3:0] O_SUBI  = 4'd4;
  localparam logic [3:0] O_SLTI  = 4'd6;
  localparam logic [3:0] O_SLTIU = 4'd7;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_e;

endpackage

// File: rtl/alu_control_mdu_if.sv
// EX-stage control/data bundle between the pipeline and alu_control_mdu.
interface alu_control_mdu_if #(parameter int DATA_W = 32);
  logic              valid;
  logic [1:0]        alu_op;
  logic [5:0]        func_code;
  logic [3:0]        other;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        alu_ctrl;
  logic              stall;
  logic              mdu_busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output valid, alu_op, func_code, other, a, b,
                  input  alu_ctrl, stall, mdu_busy, done, hi, lo);
  modport slave  (input  valid, alu_op, func_code, other, a, b,
                  output alu_ctrl, stall, mdu_busy, done, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide on
// operand magnitudes, sign fix-up in a final cycle, plus the HI/LO registers.
module mdu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  mdu_state_e          state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                is_div, neg_q, neg_r, b_zero;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opd_b;

  logic                sa, sb, fits;
  logic [DATA_W-1:0]   mag_a, mag_b, rem_n, q_fix, r_fix;
  logic [DATA_W:0]     sum, shifted;
  logic [2*DATA_W-1:0] prod_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MDU_IDLE: if (start) state_n = MDU_RUN;
      MDU_RUN:  if (cnt == CNT_W'(DATA_W - 1)) state_n = MDU_FIX;
      MDU_FIX:  state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
  end

  assign busy = (state != MDU_IDLE);

  // op[0]=1 marks the unsigned variants (multu/divu)
  assign sa    = ~op[0] & a[DATA_W-1];
  assign sb    = ~op[0] & b[DATA_W-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // acc_lo holds the multiplier (shifting out) or the dividend/quotient (shifting in)
  assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_b} : '0);
  assign shifted = {acc_hi, acc_lo[DATA_W-1]};
  assign fits    = (shifted >= {1'b0, opd_b});
  assign rem_n   = fits ? DATA_W'(shifted - {1'b0, opd_b}) : shifted[DATA_W-1:0];

  // Remainder magnitude with dividend sign reproduces A exactly on divide-by-zero
  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign q_fix    = b_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd_b  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        MDU_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opd_b  <= mag_b;
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (b == '0);
          end
          if (wr_hi) hi <= a;
          if (wr_lo) lo <= a;
        end
        MDU_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc_hi <= rem_n;
            acc_lo <= {acc_lo[DATA_W-2:0], fits};
          end else begin
            acc_hi <= sum[DATA_W:1];
            acc_lo <= {sum[0], acc_lo[DATA_W-1:1]};
          end
        end
        MDU_FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with HI/LO interlock around the iterative MDU.
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  alu_control_mdu_if.slave   bus
);

  logic       hilo_op, mdu_op, accept, busy;
  logic [3:0] alu_ctrl;

  always_comb begin
    alu_ctrl = ALU_INVALID;
    unique case (bus.alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (bus.func_code)
          F_SLL:                    alu_ctrl = ALU_SLL;
          F_SRL:                    alu_ctrl = ALU_SRL;
          F_SRA:                    alu_ctrl = ALU_SRA;
          F_ADD, F_ADDU:            alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU:            alu_ctrl = ALU_SUB;
          F_AND:                    alu_ctrl = ALU_AND;
          F_OR:                     alu_ctrl = ALU_OR;
          F_XOR:                    alu_ctrl = ALU_XOR;
          F_NOR:                    alu_ctrl = ALU_NOR;
          F_SLT:                    alu_ctrl = ALU_SLT;
          F_SLTU:                   alu_ctrl = ALU_SLTU;
          F_MFHI:                   alu_ctrl = ALU_MFHI;
          F_MFLO:                   alu_ctrl = ALU_MFLO;
          F_MTHI, F_MTLO,
          F_MULT, F_MULTU,
          F_DIV, F_DIVU:            alu_ctrl = ALU_MDU;
          default:                  alu_ctrl = ALU_INVALID;
        endcase
      end
      2'b11: begin
        case (bus.other)
          O_ADDI:  alu_ctrl = ALU_ADD;
          O_ANDI:  alu_ctrl = ALU_AND;
          O_ORI:   alu_ctrl = ALU_OR;
          O_XORI:  alu_ctrl = ALU_XOR;
          O_SUBI:  alu_ctrl = ALU_SUB;
          O_SLTI:  alu_ctrl = ALU_SLT;
          O_SLTIU: alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_INVALID;
        endcase
      end
      default: alu_ctrl = ALU_INVALID;
    endcase
  end

  assign bus.alu_ctrl = alu_ctrl;

  assign mdu_op  = (bus.alu_op == 2'b10) &&
                   (bus.func_code inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign hilo_op = mdu_op || ((bus.alu_op == 2'b10) &&
                   (bus.func_code inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO}));

  // Busy drops in the Done cycle, so a held request proceeds exactly then
  assign bus.stall    = bus.valid & hilo_op & busy;
  assign accept       = bus.valid & hilo_op & ~busy;
  assign bus.mdu_busy = busy;

  mdu_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_mdu (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (accept & mdu_op),
    .op    (bus.func_code[1:0]),
    .wr_hi (accept && (bus.func_code == F_MTHI)),
    .wr_lo (accept && (bus.func_code == F_MTLO)),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (busy),
    .done  (bus.done),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

endmodule
